// File: rtl/id_exe_pipe_reg_if.sv
// ID->EXE pipeline register bus: ID-side handshake and payload, EXE-side handshake and decoded outputs.
// The master side is the ID stage / pipeline controller; the slave side is the pipeline register.
interface id_exe_pipe_reg_if #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int WSEL_W  = 2
);
    logic                flush;
    logic                id_valid;
    logic                id_ready;
    logic [XLEN-1:0]     id_instr_in;
    logic [XLEN-1:0]     id_pc_in;
    logic [XLEN-1:0]     ext_result_in;
    logic [XLEN-1:0]     id_GPR_rs_in;
    logic [XLEN-1:0]     id_GPR_rt_in;
    logic                id_GPR_we_in;
    logic [RADDR_W-1:0]  id_GPR_waddr_in;
    logic [WSEL_W-1:0]   id_GPR_wdata_sel_in;
    logic                exe_ready;
    logic                exe_valid;
    logic [XLEN-1:0]     exe_alu_opr1_out;
    logic [XLEN-1:0]     exe_alu_opr2_out;
    logic [3:0]          exe_alu_control;
    logic                exe_illegal;
    logic                exe_GPR_we;
    logic [RADDR_W-1:0]  exe_GPR_waddr;
    logic [WSEL_W-1:0]   exe_GPR_wdata_sel;
    logic [XLEN-1:0]     exe_GPR_rt_out;
    logic [XLEN-1:0]     exe_pc_out;
    logic [XLEN-1:0]     exe_instr_out;

    modport master (
        output flush, id_valid, id_instr_in, id_pc_in, ext_result_in,
               id_GPR_rs_in, id_GPR_rt_in, id_GPR_we_in, id_GPR_waddr_in,
               id_GPR_wdata_sel_in, exe_ready,
        input  id_ready, exe_valid, exe_alu_opr1_out, exe_alu_opr2_out,
               exe_alu_control, exe_illegal, exe_GPR_we, exe_GPR_waddr,
               exe_GPR_wdata_sel, exe_GPR_rt_out, exe_pc_out, exe_instr_out
    );

    modport slave (
        input  flush, id_valid, id_instr_in, id_pc_in, ext_result_in,
               id_GPR_rs_in, id_GPR_rt_in, id_GPR_we_in, id_GPR_waddr_in,
               id_GPR_wdata_sel_in, exe_ready,
        output id_ready, exe_valid, exe_alu_opr1_out, exe_alu_opr2_out,
               exe_alu_control, exe_illegal, exe_GPR_we, exe_GPR_waddr,
               exe_GPR_wdata_sel, exe_GPR_rt_out, exe_pc_out, exe_instr_out
    );
endinterface

// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register with ALU decode in ID, 2-entry skid buffer, valid/ready handshake and flush.
// Optional bubble counter enabled by defining ID_EXE_BUBBLE_CNT_EN (adds CNT_W parameter and bubble_cnt port).
//
//   state | meaning
//   EMPTY | main and skid entries invalid, outputs idle
//   ONE   | main entry valid and driving EXE, skid free
//   TWO   | main and skid valid, id_ready low until EXE consumes
module id_exe_pipe_reg #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int WSEL_W  = 2
`ifdef ID_EXE_BUBBLE_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    id_exe_pipe_reg_if.slave bus
`ifdef ID_EXE_BUBBLE_CNT_EN
    , output logic [CNT_W-1:0] bubble_cnt
`endif
);

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] ONE   = 2'b01;
    localparam logic [1:0] TWO   = 2'b10;

    localparam logic [3:0] ALU_INVALID = 4'b0000;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_ADDU    = 4'b0011;
    localparam logic [3:0] ALU_SUB     = 4'b0100;
    localparam logic [3:0] ALU_SUBU    = 4'b0101;
    localparam logic [3:0] ALU_AND     = 4'b0110;
    localparam logic [3:0] ALU_OR      = 4'b0111;
    localparam logic [3:0] ALU_XOR     = 4'b1000;
    localparam logic [3:0] ALU_NOR     = 4'b1001;
    localparam logic [3:0] ALU_SLT     = 4'b1010;
    localparam logic [3:0] ALU_SLTU    = 4'b1011;
    localparam logic [3:0] ALU_SRL     = 4'b1100;
    localparam logic [3:0] ALU_SRA     = 4'b1101;
    localparam logic [3:0] ALU_SLL     = 4'b1110;
    localparam logic [3:0] ALU_LUI     = 4'b1111;

    typedef struct packed {
        logic [XLEN-1:0]    instr;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    opr1;
        logic [XLEN-1:0]    opr2;
        logic [XLEN-1:0]    rt;
        logic [3:0]         ctrl;
        logic               illegal;
        logic               we;
        logic [RADDR_W-1:0] waddr;
        logic [WSEL_W-1:0]  wsel;
    } entry_t;

    logic [5:0] op;
    logic [5:0] funct;
    logic [3:0] dec_ctrl;
    logic       dec_illegal;
    logic       sel_ext1;
    logic       sel_ext2;
    entry_t     din;
    entry_t     m_q;
    entry_t     s_q;
    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       load_m;
    logic       load_s;
    logic       move_s;
    logic       exe_valid;
    logic       id_ready;
    logic       accept;
    logic       consume;

    assign op    = bus.id_instr_in[31:26];
    assign funct = bus.id_instr_in[5:0];

    // Variable shifts reuse the immediate-shift ALU codes; only the operand-1 source differs.
    always_comb begin
        dec_ctrl    = ALU_INVALID;
        dec_illegal = 1'b0;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b100000: dec_ctrl = ALU_ADD;
                    6'b100001: dec_ctrl = ALU_ADDU;
                    6'b100010: dec_ctrl = ALU_SUB;
                    6'b100011: dec_ctrl = ALU_SUBU;
                    6'b100100: dec_ctrl = ALU_AND;
                    6'b100101: dec_ctrl = ALU_OR;
                    6'b100110: dec_ctrl = ALU_XOR;
                    6'b100111: dec_ctrl = ALU_NOR;
                    6'b101010: dec_ctrl = ALU_SLT;
                    6'b101011: dec_ctrl = ALU_SLTU;
                    6'b000000: dec_ctrl = ALU_SLL;
                    6'b000010: dec_ctrl = ALU_SRL;
                    6'b000011: dec_ctrl = ALU_SRA;
                    6'b000100: dec_ctrl = ALU_SLL;
                    6'b000110: dec_ctrl = ALU_SRL;
                    6'b000111: dec_ctrl = ALU_SRA;
                    default:   dec_illegal = 1'b1;
                endcase
            end
            6'b001000: dec_ctrl = ALU_ADD;
            6'b001001: dec_ctrl = ALU_ADDU;
            6'b100011: dec_ctrl = ALU_ADDU;
            6'b101011: dec_ctrl = ALU_ADDU;
            6'b001100: dec_ctrl = ALU_AND;
            6'b001101: dec_ctrl = ALU_OR;
            6'b001110: dec_ctrl = ALU_XOR;
            6'b001010: dec_ctrl = ALU_SLT;
            6'b001011: dec_ctrl = ALU_SLTU;
            6'b001111: dec_ctrl = ALU_LUI;
            default:   dec_illegal = 1'b1;
        endcase
    end

    assign sel_ext1 = (bus.id_instr_in[29:26] == 4'b0000) && !bus.id_instr_in[5]
                      && !bus.id_instr_in[3] && !bus.id_instr_in[2];
    assign sel_ext2 = bus.id_instr_in[29] | bus.id_instr_in[31];

    always_comb begin
        din.instr   = bus.id_instr_in;
        din.pc      = bus.id_pc_in;
        din.opr1    = sel_ext1 ? bus.ext_result_in : bus.id_GPR_rs_in;
        din.opr2    = sel_ext2 ? bus.ext_result_in : bus.id_GPR_rt_in;
        din.rt      = bus.id_GPR_rt_in;
        din.ctrl    = dec_ctrl;
        din.illegal = dec_illegal;
        din.we      = bus.id_GPR_we_in;
        din.waddr   = bus.id_GPR_waddr_in;
        din.wsel    = bus.id_GPR_wdata_sel_in;
    end

    assign exe_valid = (state_q != EMPTY);
    assign id_ready  = (state_q != TWO);
    assign accept    = bus.id_valid & id_ready;
    assign consume   = exe_valid & bus.exe_ready;

    always_comb begin
        state_d = state_q;
        load_m  = 1'b0;
        load_s  = 1'b0;
        move_s  = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    load_m  = 1'b1;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    load_m = 1'b1;
                end else if (accept) begin
                    state_d = TWO;
                    load_s  = 1'b1;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (consume) begin
                    state_d = ONE;
                    move_s  = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Redirect kills everything held plus whatever ID offers in the same cycle.
        if (bus.flush) begin
            state_d = EMPTY;
            load_m  = 1'b0;
            load_s  = 1'b0;
            move_s  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q <= '0;
        end else if (load_m) begin
            m_q <= din;
        end else if (move_s) begin
            m_q <= s_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_q <= '0;
        end else if (load_s) begin
            s_q <= din;
        end
    end

    assign bus.id_ready          = id_ready;
    assign bus.exe_valid         = exe_valid;
    assign bus.exe_alu_opr1_out  = m_q.opr1;
    assign bus.exe_alu_opr2_out  = m_q.opr2;
    assign bus.exe_alu_control   = m_q.ctrl;
    assign bus.exe_illegal       = m_q.illegal;
    assign bus.exe_GPR_we        = exe_valid & m_q.we & ~m_q.illegal;
    assign bus.exe_GPR_waddr     = m_q.waddr;
    assign bus.exe_GPR_wdata_sel = m_q.wsel;
    assign bus.exe_GPR_rt_out    = m_q.rt;
    assign bus.exe_pc_out        = m_q.pc;
    assign bus.exe_instr_out     = m_q.instr;

`ifdef ID_EXE_BUBBLE_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt <= '0;
        end else if (bus.exe_ready && !exe_valid && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Self-checking bench for id_exe_pipe_reg: directed scenarios plus random traffic against a queue model.
// Bubble-counter checks are compiled only when ID_EXE_BUBBLE_CNT_EN is defined.
module tb_id_exe_pipe_reg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] opr1;
        logic [31:0] opr2;
        logic [31:0] rt;
        logic [3:0]  ctrl;
        logic        ill;
        logic        we;
        logic [4:0]  waddr;
        logic [1:0]  wsel;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    ent_t mq[$];
    bit   last_acc;
    int   bub = 0;
    int   bub4 = 0;

    id_exe_pipe_reg_if #(.XLEN(32), .RADDR_W(5), .WSEL_W(2)) bus();

`ifdef ID_EXE_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt;
    logic [3:0]  bubble_cnt4;
    id_exe_pipe_reg_if #(.XLEN(32), .RADDR_W(5), .WSEL_W(2)) bus4();
    assign bus4.flush = 1'b0;
    assign bus4.id_valid = 1'b0;
    assign bus4.id_instr_in = '0;
    assign bus4.id_pc_in = '0;
    assign bus4.ext_result_in = '0;
    assign bus4.id_GPR_rs_in = '0;
    assign bus4.id_GPR_rt_in = '0;
    assign bus4.id_GPR_we_in = 1'b0;
    assign bus4.id_GPR_waddr_in = '0;
    assign bus4.id_GPR_wdata_sel_in = '0;
    assign bus4.exe_ready = bus.exe_ready;

    id_exe_pipe_reg #(.XLEN(32), .RADDR_W(5), .WSEL_W(2), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4), .bubble_cnt(bubble_cnt4)
    );
`endif

    id_exe_pipe_reg #(.XLEN(32), .RADDR_W(5), .WSEL_W(2)
`ifdef ID_EXE_BUBBLE_CNT_EN
        , .CNT_W(16)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef ID_EXE_BUBBLE_CNT_EN
        , .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Decode table: {illegal, control}
    function automatic logic [4:0] ref_dec(input logic [31:0] i);
        logic [5:0] op;
        logic [5:0] fn;
        op = i[31:26];
        fn = i[5:0];
        if (op == 6'b000000) begin
            case (fn)
                6'b100000: return 5'h02;
                6'b100001: return 5'h03;
                6'b100010: return 5'h04;
                6'b100011: return 5'h05;
                6'b100100: return 5'h06;
                6'b100101: return 5'h07;
                6'b100110: return 5'h08;
                6'b100111: return 5'h09;
                6'b101010: return 5'h0A;
                6'b101011: return 5'h0B;
                6'b000000, 6'b000100: return 5'h0E;
                6'b000010, 6'b000110: return 5'h0C;
                6'b000011, 6'b000111: return 5'h0D;
                default: return 5'h10;
            endcase
        end
        case (op)
            6'b001000: return 5'h02;
            6'b001001, 6'b100011, 6'b101011: return 5'h03;
            6'b001100: return 5'h06;
            6'b001101: return 5'h07;
            6'b001110: return 5'h08;
            6'b001010: return 5'h0A;
            6'b001011: return 5'h0B;
            6'b001111: return 5'h0F;
            default: return 5'h10;
        endcase
    endfunction

    function automatic ent_t ref_entry();
        ent_t e;
        logic [31:0] i;
        logic [4:0] d;
        i = bus.id_instr_in;
        d = ref_dec(i);
        e.instr = i;
        e.pc = bus.id_pc_in;
        e.opr1 = (i[29:26] == 4'd0 && i[5] == 1'b0 && i[3] == 1'b0 && i[2] == 1'b0)
                 ? bus.ext_result_in : bus.id_GPR_rs_in;
        e.opr2 = (i[29] || i[31]) ? bus.ext_result_in : bus.id_GPR_rt_in;
        e.rt = bus.id_GPR_rt_in;
        e.ctrl = d[3:0];
        e.ill = d[4];
        e.we = bus.id_GPR_we_in & ~d[4];
        e.waddr = bus.id_GPR_waddr_in;
        e.wsel = bus.id_GPR_wdata_sel_in;
        return e;
    endfunction

    function automatic ent_t obs();
        return {bus.exe_instr_out, bus.exe_pc_out, bus.exe_alu_opr1_out, bus.exe_alu_opr2_out,
                bus.exe_GPR_rt_out, bus.exe_alu_control, bus.exe_illegal, bus.exe_GPR_we,
                bus.exe_GPR_waddr, bus.exe_GPR_wdata_sel};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] r_fn[16] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
                                 6'b100110, 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
                                 6'b000011, 6'b000100, 6'b000110, 6'b000111};
        logic [5:0] i_op[10] = '{6'b001000, 6'b001001, 6'b100011, 6'b101011, 6'b001100, 6'b001101,
                                 6'b001110, 6'b001010, 6'b001011, 6'b001111};
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 3))
            0: x[31:26] = 6'b000000;
            1: begin x[31:26] = 6'b000000; x[5:0] = r_fn[$urandom_range(0, 15)]; end
            2: x[31:26] = i_op[$urandom_range(0, 9)];
            default: ;
        endcase
        return x;
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] ext, input logic we);
        bus.id_valid = 1'b1;
        bus.id_instr_in = instr;
        bus.id_GPR_rs_in = rs;
        bus.id_GPR_rt_in = rt;
        bus.ext_result_in = ext;
        bus.id_GPR_we_in = we;
        bus.id_pc_in = $urandom;
        bus.id_GPR_waddr_in = 5'($urandom);
        bus.id_GPR_wdata_sel_in = 2'($urandom);
    endtask

    task automatic tick();
        ent_t e;
        bit acc;
        bit con;
        int n;
        n = mq.size();
        acc = bus.id_valid && (n < 2);
        con = bus.exe_ready && (n > 0);
        e = ref_entry();
        if (bus.exe_ready && n == 0 && bub < 65535) bub++;
        if (bus.exe_ready && bub4 < 15) bub4++;
        @(posedge clk);
        if (bus.flush) mq.delete();
        else begin
            if (con) void'(mq.pop_front());
            if (acc) mq.push_back(e);
        end
        last_acc = acc && !bus.flush;
        #1;
    endtask

    task automatic drain();
        bus.id_valid = 1'b0;
        bus.flush = 1'b0;
        bus.exe_ready = 1'b1;
        repeat (3) tick();
        bus.exe_ready = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        mq.delete();
        bub = 0;
        bub4 = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus.flush = 1'b0;
        bus.id_valid = 1'b0;
        bus.exe_ready = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        bus.id_valid = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.exe_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.exe_valid); end
        checks++;
        if (obs() !== '0) begin errors++; $display("FAIL reset_outputs got=%h want=0", obs()); end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL reset_id_ready got=%b want=1", bus.id_ready); end
    endtask

    task automatic test_addu();
        drive({6'b0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100001}, 32'd5, 32'd7, 32'h21, 1'b1);
        tick();
        bus.id_valid = 1'b0;
        checks++;
        if (bus.exe_valid !== 1'b1 || bus.exe_alu_control !== 4'b0011 || bus.exe_alu_opr1_out !== 32'd5
            || bus.exe_alu_opr2_out !== 32'd7 || bus.exe_GPR_we !== 1'b1)
        begin
            errors++;
            $display("FAIL addu got v=%b c=%b o1=%h o2=%h we=%b want v=1 c=0011 o1=5 o2=7 we=1",
                     bus.exe_valid, bus.exe_alu_control, bus.exe_alu_opr1_out, bus.exe_alu_opr2_out, bus.exe_GPR_we);
        end
        drain();
    endtask

    task automatic test_sll_ori();
        drive({6'b0, 5'd0, 5'd2, 5'd3, 5'd4, 6'b000000}, 32'hDEAD, 32'h1, 32'h4, 1'b1);
        tick();
        checks++;
        if (bus.exe_alu_control !== 4'b1110 || bus.exe_alu_opr1_out !== 32'd4 || bus.exe_alu_opr2_out !== 32'd1) begin
            errors++;
            $display("FAIL sll got c=%b o1=%h o2=%h want c=1110 o1=4 o2=1",
                     bus.exe_alu_control, bus.exe_alu_opr1_out, bus.exe_alu_opr2_out);
        end
        drive({6'b001101, 5'd1, 5'd2, 16'h00FF}, 32'h55, 32'h1234, 32'hFF, 1'b1);
        bus.exe_ready = 1'b1;
        tick();
        bus.id_valid = 1'b0;
        checks++;
        if (bus.exe_valid !== 1'b1 || bus.exe_alu_control !== 4'b0111 || bus.exe_alu_opr2_out !== 32'hFF
            || bus.exe_alu_opr1_out !== 32'h55) begin
            errors++;
            $display("FAIL ori got v=%b c=%b o1=%h o2=%h want v=1 c=0111 o1=55 o2=ff",
                     bus.exe_valid, bus.exe_alu_control, bus.exe_alu_opr1_out, bus.exe_alu_opr2_out);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] got[$];
        bit c_pending;
        a = {6'b0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100001};
        b = {6'b001101, 5'd4, 5'd5, 16'h1234};
        c = {6'b001111, 5'd0, 5'd6, 16'hABCD};
        bus.exe_ready = 1'b0;
        drive(a, 32'h1, 32'h2, 32'h3, 1'b1);
        tick();
        drive(b, 32'h4, 32'h5, 32'h6, 1'b1);
        tick();
        checks++;
        if (bus.id_ready !== 1'b0) begin errors++; $display("FAIL b2b_full got id_ready=%b want 0", bus.id_ready); end
        drive(c, 32'h7, 32'h8, 32'h9, 1'b1);
        repeat (2) tick();
        checks++;
        if (bus.id_ready !== 1'b0 || bus.exe_instr_out !== a) begin
            errors++;
            $display("FAIL b2b_hold got id_ready=%b instr=%h want 0 %h", bus.id_ready, bus.exe_instr_out, a);
        end
        bus.exe_ready = 1'b1;
        c_pending = 1'b1;
        for (int k = 0; k < 20 && got.size() < 3; k++) begin
            if (bus.exe_valid) got.push_back(bus.exe_instr_out);
            tick();
            if (c_pending && last_acc) begin
                c_pending = 1'b0;
                bus.id_valid = 1'b0;
            end
        end
        bus.id_valid = 1'b0;
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL b2b_count got=%0d want=3", got.size());
        end else begin
            checks++;
            if (got[0] !== a || got[1] !== b || got[2] !== c) begin
                errors++;
                $display("FAIL b2b_order got %h %h %h want %h %h %h", got[0], got[1], got[2], a, b, c);
            end
        end
        drain();
    endtask

    task automatic test_flush();
        bus.exe_ready = 1'b0;
        drive(rand_instr(), $urandom, $urandom, $urandom, 1'b1);
        tick();
        drive({6'b0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100001}, $urandom, $urandom, $urandom, 1'b1);
        tick();
        drive({6'b001001, 5'd1, 5'd2, 16'h0001}, $urandom, $urandom, $urandom, 1'b1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.id_valid = 1'b0;
        checks++;
        if (bus.exe_valid !== 1'b0 || bus.exe_GPR_we !== 1'b0 || bus.id_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush got v=%b we=%b rdy=%b want 0 0 1", bus.exe_valid, bus.exe_GPR_we, bus.id_ready);
        end
        bus.exe_ready = 1'b1;
        tick();
        checks++;
        if (bus.exe_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got v=%b want 0", bus.exe_valid); end
        drain();
    endtask

    task automatic test_illegal();
        logic [31:0] i;
        i = $urandom;
        i[31:26] = 6'b111111;
        drive(i, $urandom, $urandom, $urandom, 1'b1);
        tick();
        bus.id_valid = 1'b0;
        checks++;
        if (bus.exe_valid !== 1'b1 || bus.exe_illegal !== 1'b1 || bus.exe_alu_control !== 4'b0000
            || bus.exe_GPR_we !== 1'b0) begin
            errors++;
            $display("FAIL illegal got v=%b ill=%b c=%b we=%b want 1 1 0000 0",
                     bus.exe_valid, bus.exe_illegal, bus.exe_alu_control, bus.exe_GPR_we);
        end
        drain();
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            drive(rand_instr(), $urandom, $urandom, $urandom, 1'($urandom));
            bus.id_valid = ($urandom_range(0, 2) != 0);
            bus.exe_ready = ($urandom_range(0, 2) != 0);
            bus.flush = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if (bus.exe_valid !== (mq.size() > 0) || bus.id_ready !== (mq.size() < 2)) begin
                errors++;
                $display("FAIL rand_hs cyc=%0d got v=%b rdy=%b want v=%b rdy=%b",
                         k, bus.exe_valid, bus.id_ready, mq.size() > 0, mq.size() < 2);
            end
            checks++;
            if (mq.size() > 0) begin
                if (obs() !== mq[0]) begin
                    errors++;
                    $display("FAIL rand_data cyc=%0d got=%h want=%h", k, obs(), mq[0]);
                end
            end else if (bus.exe_GPR_we !== 1'b0) begin
                errors++;
                $display("FAIL rand_we_idle cyc=%0d got=%b want=0", k, bus.exe_GPR_we);
            end
`ifdef ID_EXE_BUBBLE_CNT_EN
            checks++;
            if (bubble_cnt !== 16'(bub)) begin
                errors++;
                $display("FAIL rand_bubble cyc=%0d got=%0d want=%0d", k, bubble_cnt, bub);
            end
`endif
        end
        drain();
    endtask

    task automatic test_reset_mid();
        bus.exe_ready = 1'b0;
        drive(rand_instr(), $urandom, $urandom, $urandom, 1'b1);
        tick();
        drive({6'b0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100001}, $urandom, $urandom, $urandom, 1'b1);
        tick();
        bus.id_valid = 1'b0;
        #3;
        reset = 1'b0;
        mq.delete();
        bub = 0;
        bub4 = 0;
        #1;
        checks++;
        if (bus.exe_valid !== 1'b0 || bus.exe_GPR_we !== 1'b0 || bus.id_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid got v=%b we=%b rdy=%b want 0 0 1", bus.exe_valid, bus.exe_GPR_we, bus.id_ready);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        checks++;
        if (bus.exe_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_after got v=%b want 0", bus.exe_valid); end
    endtask

`ifdef ID_EXE_BUBBLE_CNT_EN
    task automatic test_bubble();
        bus.exe_ready = 1'b0;
        bus.id_valid = 1'b0;
        bus.flush = 1'b0;
        apply_reset();
        bus.exe_ready = 1'b1;
        repeat (10) tick();
        checks++;
        if (bubble_cnt !== 16'd10) begin errors++; $display("FAIL bubble_10 got=%0d want=10", bubble_cnt); end
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        checks++;
        if (bubble_cnt !== 16'd11) begin errors++; $display("FAIL bubble_flush got=%0d want=11", bubble_cnt); end
        repeat (20) tick();
        checks++;
        if (bubble_cnt4 !== 4'hF) begin errors++; $display("FAIL bubble_sat got=%0d want=15", bubble_cnt4); end
        bus.exe_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_addu();
        test_sll_ori();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_random();
        test_reset_mid();
`ifdef ID_EXE_BUBBLE_CNT_EN
        test_bubble();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
